// File: rtl/ss_pkg.sv
// Shared definitions for the sign-magnitude stochastic add/sub window block.
// Holds the constant-function count-width helper and the output MODE encodings.
// No ports; imported by ss_popcount and ss_addsub_n_window.
package ss_pkg;

  localparam int SS_MODE_THRESH   = 0;
  localparam int SS_MODE_SIGDELTA = 1;

  // Smallest r with 2**r >= value; usable in parameter expressions.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ss_popcount.sv
// Combinational population count of an N-bit vector.
// Ports: vec (N bits in), count (CW bits out, number of ones in vec).
// CW must be wide enough to hold N.
module ss_popcount
  import ss_pkg::*;
#(
  parameter int N  = 2,
  parameter int CW = 2
) (
  input  logic [N-1:0]  vec,
  output logic [CW-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + CW'(vec[i]);
    end
  end

endmodule

// File: rtl/ss_addsub_n_window.sv
// Sign-magnitude stochastic adder/subtractor over a sliding window of WIN samples
// for N bipolar streams. Ports: CLK, INIT (async active-high reset), IN/SIGN (N bits
// each), OUT/SIGN_out (registered output stream), READY (window full), NET_MAG.
// Optional macro SS_ADDSUB_SIGN_HYST_EN adds HYST margin to output sign changes.
module ss_addsub_n_window
  import ss_pkg::*;
#(
  parameter int N        = 2,
  parameter int WIN      = 4,
  parameter int MODE     = SS_MODE_SIGDELTA,
  parameter int LOWERLIM = 0,
  parameter int HYST     = 1,
  localparam int CW      = clog2(N*WIN+1)
) (
  input  logic          CLK,
  input  logic          INIT,
  input  logic [N-1:0]  IN,
  input  logic [N-1:0]  SIGN,
  output logic          OUT,
  output logic          SIGN_out,
  output logic          READY,
  output logic [CW-1:0] NET_MAG
);

  localparam int AW = CW + 1;
  localparam int FW = clog2(WIN+1);

`ifdef SS_ADDSUB_SIGN_HYST_EN
  localparam bit HYST_EN = 1'b1;
`else
  localparam bit HYST_EN = 1'b0;
`endif

  localparam logic [AW-1:0] MARGIN   = HYST_EN ? AW'(HYST) : AW'(0);
  localparam logic [AW-1:0] WIN_A    = AW'(WIN);
  localparam logic [AW-1:0] ACC_MAX  = AW'(WIN-1);
  localparam logic [FW-1:0] FILL_MAX = FW'(WIN);

  // Per-input histories; bit 0 is the newest sample, bit WIN-1 leaves next edge.
  logic [WIN-1:0] pos_hist [N];
  logic [WIN-1:0] neg_hist [N];

  logic [N-1:0]  p_in, n_in, p_old, n_old;
  logic [CW-1:0] pc_p_in, pc_p_old, pc_n_in, pc_n_old;
  logic [CW-1:0] pos_cnt, neg_cnt;
  logic [AW-1:0] acc;
  logic [FW-1:0] fill;

  assign p_in = IN & ~SIGN;
  assign n_in = IN & SIGN;

  for (genvar g = 0; g < N; g++) begin : g_oldest
    assign p_old[g] = pos_hist[g][WIN-1];
    assign n_old[g] = neg_hist[g][WIN-1];
  end

  ss_popcount #(.N(N), .CW(CW)) u_pc_p_in  (.vec(p_in),  .count(pc_p_in));
  ss_popcount #(.N(N), .CW(CW)) u_pc_p_old (.vec(p_old), .count(pc_p_old));
  ss_popcount #(.N(N), .CW(CW)) u_pc_n_in  (.vec(n_in),  .count(pc_n_in));
  ss_popcount #(.N(N), .CW(CW)) u_pc_n_old (.vec(n_old), .count(pc_n_old));

  // Entering and leaving bits of the same input net out in one update, so a
  // sample that replaces an identical one leaves the count unchanged.
  logic [CW-1:0] pos_next, neg_next;
  assign pos_next = pos_cnt + pc_p_in - pc_p_old;
  assign neg_next = neg_cnt + pc_n_in - pc_n_old;

  // Sign and magnitude from the registered counters.
  logic [AW-1:0] pos_x, neg_x;
  logic          pos_wins, neg_wins, sgn;
  logic [CW-1:0] mag;

  assign pos_x = {1'b0, pos_cnt};
  assign neg_x = {1'b0, neg_cnt};

  always_comb begin
    pos_wins = pos_x > (neg_x + MARGIN);
    neg_wins = neg_x > (pos_x + MARGIN);
    sgn      = 1'b0;
    mag      = '0;
    if (HYST_EN) begin
      // Flip only when the opposite polarity leads by more than the margin.
      sgn = SIGN_out ? ~pos_wins : neg_wins;
    end else begin
      sgn = neg_cnt > pos_cnt;
    end
    // Magnitude relative to the chosen sign; a held sign can point the
    // "wrong" way, in which case the magnitude clamps to zero.
    if (sgn) begin
      mag = (neg_cnt >= pos_cnt) ? neg_cnt - pos_cnt : '0;
    end else begin
      mag = (pos_cnt >= neg_cnt) ? pos_cnt - neg_cnt : '0;
    end
  end

  // Sigma-delta: accumulate magnitude, emit a one per WIN units. The residue
  // saturates at WIN-1 so densities above 1 clip instead of growing acc.
  logic [AW-1:0] acc_base, acc_sum, acc_nxt;
  logic          sd_out, thresh_out;

  always_comb begin
    acc_base = (sgn != SIGN_out) ? '0 : acc;
    acc_sum  = acc_base + AW'(mag);
    sd_out   = 1'b0;
    acc_nxt  = acc_sum;
    if (acc_sum >= WIN_A) begin
      sd_out  = 1'b1;
      acc_nxt = ((acc_sum - WIN_A) > ACC_MAX) ? ACC_MAX : (acc_sum - WIN_A);
    end
  end

  assign thresh_out = int'(mag) > LOWERLIM;

  always_ff @(posedge CLK or posedge INIT) begin
    if (INIT) begin
      for (int i = 0; i < N; i++) begin
        pos_hist[i] <= '0;
        neg_hist[i] <= '0;
      end
      pos_cnt  <= '0;
      neg_cnt  <= '0;
      acc      <= '0;
      fill     <= '0;
      OUT      <= 1'b0;
      SIGN_out <= 1'b0;
      NET_MAG  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        pos_hist[i] <= {pos_hist[i][WIN-2:0], p_in[i]};
        neg_hist[i] <= {neg_hist[i][WIN-2:0], n_in[i]};
      end
      pos_cnt <= pos_next;
      neg_cnt <= neg_next;
      if (fill != FILL_MAX) begin
        fill <= fill + FW'(1);
      end
      SIGN_out <= sgn;
      NET_MAG  <= mag;
      if (MODE == SS_MODE_THRESH) begin
        OUT <= thresh_out;
        acc <= '0;
      end else begin
        OUT <= sd_out;
        acc <= acc_nxt;
      end
    end
  end

  assign READY = (fill == FILL_MAX);

  a_cnt_range: assert property (@(posedge CLK) disable iff (INIT)
    (int'(pos_cnt) <= N*WIN) && (int'(neg_cnt) <= N*WIN));

endmodule

// File: tb/tb_ss_addsub_n_window.sv
// Self-checking bench for ss_addsub_n_window (N=2, WIN=4, MODE 1 plus a MODE 0
// instance). Reference model keeps the last WIN samples and sums them directly.
// Ports: none.
module tb_ss_addsub_n_window;

  localparam int N    = 2;
  localparam int WIN  = 4;
  localparam int HYST = 1;

`ifdef SS_ADDSUB_SIGN_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       INIT = 1'b0;
  logic [1:0] IN = 2'b00;
  logic [1:0] SIGN = 2'b00;
  logic       OUT, SIGN_out, READY;
  logic [3:0] NET_MAG;
  logic       OUT0, SIGN_out0, READY0;
  logic [3:0] NET_MAG0;

  int checks_total  = 0;
  int checks_passed = 0;

  ss_addsub_n_window #(.N(N), .WIN(WIN), .MODE(1), .LOWERLIM(0), .HYST(HYST)) dut (
    .CLK(CLK), .INIT(INIT), .IN(IN), .SIGN(SIGN),
    .OUT(OUT), .SIGN_out(SIGN_out), .READY(READY), .NET_MAG(NET_MAG)
  );

  ss_addsub_n_window #(.N(N), .WIN(WIN), .MODE(0), .LOWERLIM(0), .HYST(HYST)) dut0 (
    .CLK(CLK), .INIT(INIT), .IN(IN), .SIGN(SIGN),
    .OUT(OUT0), .SIGN_out(SIGN_out0), .READY(READY0), .NET_MAG(NET_MAG0)
  );

  always #5 CLK = ~CLK;

  // Reference model state
  logic [1:0] win_in [WIN];
  logic [1:0] win_sg [WIN];
  int m_pos, m_neg, m_acc, m_fill, m_mag;
  bit m_out, m_out0, m_sgn;

  task automatic model_reset();
    for (int k = 0; k < WIN; k++) begin
      win_in[k] = 2'b00;
      win_sg[k] = 2'b00;
    end
    m_pos = 0; m_neg = 0; m_acc = 0; m_fill = 0; m_mag = 0;
    m_out = 0; m_out0 = 0; m_sgn = 0;
  endtask

  task automatic model_edge(input logic [1:0] in_v, input logic [1:0] sg_v);
    int sg, mag, base, s;
    // Output stage works from the window totals of the previous edge.
    if (!HYST_ON)      sg = (m_neg > m_pos) ? 1 : 0;
    else if (m_sgn == 0) sg = (m_neg - m_pos > HYST) ? 1 : 0;
    else                 sg = (m_pos - m_neg > HYST) ? 0 : 1;
    mag = sg ? (m_neg - m_pos) : (m_pos - m_neg);
    if (mag < 0) mag = 0;
    base = (sg != int'(m_sgn)) ? 0 : m_acc;
    s = base + mag;
    if (s >= WIN) begin
      m_out = 1;
      m_acc = (s - WIN < WIN - 1) ? s - WIN : WIN - 1;
    end else begin
      m_out = 0;
      m_acc = s;
    end
    m_out0 = (mag > 0);
    m_sgn  = sg[0];
    m_mag  = mag;
    for (int k = WIN - 1; k > 0; k--) begin
      win_in[k] = win_in[k-1];
      win_sg[k] = win_sg[k-1];
    end
    win_in[0] = in_v;
    win_sg[0] = sg_v;
    m_pos = 0; m_neg = 0;
    for (int k = 0; k < WIN; k++)
      for (int b = 0; b < N; b++)
        if (win_in[k][b]) begin
          if (win_sg[k][b]) m_neg++;
          else              m_pos++;
        end
    if (m_fill < WIN) m_fill++;
  endtask

  // Present a sample, let the DUT capture it, then sample outputs 1 time unit later.
  task automatic drive(input logic [1:0] in_v, input logic [1:0] sg_v);
    IN = in_v;
    SIGN = sg_v;
    @(posedge CLK);
    model_edge(in_v, sg_v);
    #1;
  endtask

  task automatic apply_reset();
    IN = 2'b00;
    SIGN = 2'b00;
    INIT = 1'b1;
    @(posedge CLK);
    #3;
    INIT = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    #2;
    INIT = 1'b1;
    #1;
    checks_total++; if (OUT !== 1'b0) $display("FAIL rst_out got=%b exp=0", OUT); else checks_passed++;
    checks_total++; if (SIGN_out !== 1'b0) $display("FAIL rst_sign got=%b exp=0", SIGN_out); else checks_passed++;
    checks_total++; if (READY !== 1'b0) $display("FAIL rst_ready got=%b exp=0", READY); else checks_passed++;
    checks_total++; if (NET_MAG !== 4'd0) $display("FAIL rst_mag got=%0d exp=0", NET_MAG); else checks_passed++;
    checks_total++; if (OUT0 !== 1'b0) $display("FAIL rst_out0 got=%b exp=0", OUT0); else checks_passed++;
    @(posedge CLK);
    #1;
    checks_total++; if (READY !== 1'b0 || NET_MAG !== 4'd0) $display("FAIL rst_hold ready=%b mag=%0d exp=0/0", READY, NET_MAG); else checks_passed++;
    #2;
    INIT = 1'b0;
    model_reset();
  endtask

  task automatic test_init_midstream();
    logic [1:0] ri, rs;
    for (int c = 0; c < 10; c++) begin
      ri = 2'($urandom); rs = 2'($urandom);
      drive(ri, rs);
      checks_total++; if (NET_MAG !== 4'(m_mag) || OUT !== m_out) $display("FAIL mid_pre c=%0d mag=%0d out=%b exp=%0d/%b", c, NET_MAG, OUT, m_mag, m_out); else checks_passed++;
    end
    // Assert INIT away from any clock edge; outputs must clear without a clock.
    #($urandom_range(1, 7));
    INIT = 1'b1;
    #1;
    checks_total++; if ({OUT, SIGN_out, READY, NET_MAG} !== 7'd0) $display("FAIL mid_async out=%b sign=%b ready=%b mag=%0d exp=all 0", OUT, SIGN_out, READY, NET_MAG); else checks_passed++;
    IN = 2'($urandom); SIGN = 2'($urandom);
    @(posedge CLK);
    #1;
    checks_total++; if ({OUT, SIGN_out, READY, NET_MAG} !== 7'd0 || dut.acc !== 5'd0) $display("FAIL mid_hold out=%b ready=%b mag=%0d acc=%0d exp=all 0", OUT, READY, NET_MAG, dut.acc); else checks_passed++;
    #($urandom_range(1, 7));
    INIT = 1'b0;
    model_reset();
    for (int e = 1; e <= 8; e++) begin
      ri = 2'($urandom); rs = 2'($urandom);
      drive(ri, rs);
      checks_total++; if (READY !== (e >= WIN)) $display("FAIL mid_ready edge=%0d got=%b exp=%b", e, READY, e >= WIN); else checks_passed++;
      checks_total++; if (NET_MAG !== 4'(m_mag) || SIGN_out !== m_sgn) $display("FAIL mid_post edge=%0d mag=%0d sign=%b exp=%0d/%b", e, NET_MAG, SIGN_out, m_mag, m_sgn); else checks_passed++;
    end
  endtask

  task automatic test_ramp();
    int exp_mag;
    apply_reset();
    for (int c = 1; c <= 12; c++) begin
      drive(2'b01, 2'b00);
      exp_mag = (c - 1 > WIN) ? WIN : c - 1;
      checks_total++; if (NET_MAG !== 4'(exp_mag)) $display("FAIL ramp_mag c=%0d got=%0d exp=%0d", c, NET_MAG, exp_mag); else checks_passed++;
      checks_total++; if (SIGN_out !== 1'b0) $display("FAIL ramp_sign c=%0d got=%b exp=0", c, SIGN_out); else checks_passed++;
      checks_total++; if (OUT !== ((c >= 5) ? 1'b1 : m_out)) $display("FAIL ramp_out c=%0d got=%b exp=%b", c, OUT, (c >= 5) ? 1'b1 : m_out); else checks_passed++;
    end
  endtask

  task automatic test_cancel();
    apply_reset();
    for (int c = 1; c <= 12; c++) begin
      drive(2'b11, 2'b10);
      checks_total++; if (NET_MAG !== 4'd0 || SIGN_out !== 1'b0) $display("FAIL cancel_mag c=%0d mag=%0d sign=%b exp=0/0", c, NET_MAG, SIGN_out); else checks_passed++;
      checks_total++; if (OUT !== 1'b0) $display("FAIL cancel_out c=%0d got=%b exp=0", c, OUT); else checks_passed++;
      checks_total++; if (OUT0 !== 1'b0) $display("FAIL cancel_out_m0 c=%0d got=%b exp=0", c, OUT0); else checks_passed++;
    end
  endtask

  task automatic test_half_density();
    int ones;
    apply_reset();
    for (int c = 0; c < 8; c++) drive((c % 2 == 0) ? 2'b01 : 2'b00, 2'b00);
    ones = 0;
    for (int c = 8; c < 24; c++) begin
      drive((c % 2 == 0) ? 2'b01 : 2'b00, 2'b00);
      if (OUT === 1'b1) ones++;
      checks_total++; if (NET_MAG !== 4'd2) $display("FAIL half_mag c=%0d got=%0d exp=2", c, NET_MAG); else checks_passed++;
      checks_total++; if (OUT !== m_out) $display("FAIL half_out c=%0d got=%b exp=%b", c, OUT, m_out); else checks_passed++;
    end
    checks_total++; if (ones < 7 || ones > 9) $display("FAIL half_density got=%0d exp=8+-1", ones); else checks_passed++;
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int c = 1; c <= 10; c++) begin
      drive(2'b11, 2'b11);
      if (c >= 5) begin
        checks_total++; if (NET_MAG !== 4'd8 || SIGN_out !== 1'b1) $display("FAIL sat_mag c=%0d mag=%0d sign=%b exp=8/1", c, NET_MAG, SIGN_out); else checks_passed++;
        checks_total++; if (OUT !== 1'b1) $display("FAIL sat_out c=%0d got=%b exp=1", c, OUT); else checks_passed++;
        checks_total++; if (dut.acc !== 5'd3) $display("FAIL sat_acc c=%0d got=%0d exp=3", c, dut.acc); else checks_passed++;
      end
    end
    for (int c = 1; c <= 8; c++) begin
      drive(2'b11, 2'b00);
      checks_total++; if (OUT !== m_out || SIGN_out !== m_sgn || NET_MAG !== 4'(m_mag)) $display("FAIL flip_model c=%0d out=%b sign=%b mag=%0d exp=%b/%b/%0d", c, OUT, SIGN_out, NET_MAG, m_out, m_sgn, m_mag); else checks_passed++;
      checks_total++; if (dut.acc !== 5'(m_acc)) $display("FAIL flip_acc c=%0d got=%0d exp=%0d", c, dut.acc, m_acc); else checks_passed++;
    end
    checks_total++; if (SIGN_out !== 1'b0 || NET_MAG !== 4'd8) $display("FAIL flip_final sign=%b mag=%0d exp=0/8", SIGN_out, NET_MAG); else checks_passed++;
  endtask

  task automatic test_hyst_alt();
    // Per-sample nets +1,-1,+1,0,-1,+1,-1,0 keep the windowed net within +-1.
    logic [1:0] pin [8];
    logic [1:0] psg [8];
    bit saw_neg;
    pin = '{2'b01, 2'b01, 2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00};
    psg = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
    saw_neg = 0;
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      drive(pin[c % 8], psg[c % 8]);
      if (SIGN_out === 1'b1) saw_neg = 1;
      checks_total++; if (SIGN_out !== m_sgn || NET_MAG !== 4'(m_mag) || OUT !== m_out) $display("FAIL alt_model c=%0d sign=%b mag=%0d out=%b exp=%b/%0d/%b", c, SIGN_out, NET_MAG, OUT, m_sgn, m_mag, m_out); else checks_passed++;
    end
    checks_total++; if (saw_neg !== !HYST_ON) $display("FAIL alt_sign_toggle got=%b exp=%b", saw_neg, !HYST_ON); else checks_passed++;
  endtask

  task automatic test_random();
    logic [1:0] ri, rs;
    apply_reset();
    for (int c = 0; c < 200; c++) begin
      ri = 2'($urandom); rs = 2'($urandom);
      drive(ri, rs);
      checks_total++; if (OUT !== m_out || SIGN_out !== m_sgn || NET_MAG !== 4'(m_mag) || READY !== (m_fill == WIN)) $display("FAIL rand c=%0d out=%b sign=%b mag=%0d ready=%b exp=%b/%b/%0d/%b", c, OUT, SIGN_out, NET_MAG, READY, m_out, m_sgn, m_mag, m_fill == WIN); else checks_passed++;
      checks_total++; if (OUT0 !== m_out0) $display("FAIL rand_m0 c=%0d got=%b exp=%b", c, OUT0, m_out0); else checks_passed++;
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_init_midstream();
    test_ramp();
    test_cancel();
    test_half_density();
    test_saturate();
    test_hyst_alt();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
